// File: rtl/vga_sync_if.sv
// Raster timing bundle produced by vga_sync_gen and consumed by the pattern generator.
interface vga_sync_if;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic [9:0] col_count;
    logic [9:0] row_count;
    logic       frame_start;
    logic       hsync_dly;
    logic       vsync_dly;

    modport master (
        output hsync, vsync, active, col_count, row_count,
               frame_start, hsync_dly, vsync_dly
    );

    modport slave (
        input  hsync, vsync, active, col_count, row_count,
               frame_start, hsync_dly, vsync_dly
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Free-running VGA raster counter with registered sync/active/coordinate outputs
// and an optional shift-register delay on the sync copies.
module vga_sync_gen #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int SYNC_DELAY  = 0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    vga_sync_if.master vga
);

    localparam logic [9:0] COL_LAST  = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST  = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] ACT_COLS  = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS  = 10'(ACTIVE_ROWS);
    localparam logic [9:0] HS_FIRST  = 10'(ACTIVE_COLS + H_FRONT);
    localparam logic [9:0] HS_LAST   = 10'(ACTIVE_COLS + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(ACTIVE_ROWS + V_FRONT);
    localparam logic [9:0] VS_LAST   = 10'(ACTIVE_ROWS + V_FRONT + V_SYNC - 1);

    logic [9:0] col_r, row_r;
    logic [9:0] col_next_s, row_next_s;
    logic       active_s, hsync_s, vsync_s, frame_start_s;

    logic [9:0] col_out_r, row_out_r;
    logic       active_r, hsync_r, vsync_r, frame_start_r;

    // Next raster position: column wraps every line, row wraps every frame.
    always_comb begin
        col_next_s = col_r;
        row_next_s = row_r;
        if (col_r == COL_LAST) begin
            col_next_s = 10'd0;
            if (row_r == ROW_LAST) begin
                row_next_s = 10'd0;
            end else begin
                row_next_s = row_r + 10'd1;
            end
        end else begin
            col_next_s = col_r + 10'd1;
        end
    end

    // Decode the current counter position into timing flags (syncs active-low).
    always_comb begin
        active_s      = (col_r < ACT_COLS) && (row_r < ACT_ROWS);
        hsync_s       = !((col_r >= HS_FIRST) && (col_r <= HS_LAST));
        vsync_s       = !((row_r >= VS_FIRST) && (row_r <= VS_LAST));
        frame_start_s = (col_r == 10'd0) && (row_r == 10'd0);
    end

    // Raster position counters.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            col_r <= 10'd0;
            row_r <= 10'd0;
        end else begin
            col_r <= col_next_s;
            row_r <= row_next_s;
        end
    end

    // Output stage: every output registered from the same counter value.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            col_out_r     <= 10'd0;
            row_out_r     <= 10'd0;
            active_r      <= 1'b0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            frame_start_r <= 1'b0;
        end else begin
            col_out_r     <= col_r;
            row_out_r     <= row_r;
            active_r      <= active_s;
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            frame_start_r <= frame_start_s;
        end
    end

    assign vga.col_count   = col_out_r;
    assign vga.row_count   = row_out_r;
    assign vga.active      = active_r;
    assign vga.hsync       = hsync_r;
    assign vga.vsync       = vsync_r;
    assign vga.frame_start = frame_start_r;

    generate
        if (SYNC_DELAY == 0) begin : g_no_dly
            assign vga.hsync_dly = hsync_r;
            assign vga.vsync_dly = vsync_r;
        end else begin : g_dly
            logic [SYNC_DELAY-1:0] hpipe_r, vpipe_r;

            // Sync delay line; preset to the inactive level so it never glitches low after reset.
            always_ff @(posedge i_Clk or negedge i_Rst_L) begin
                if (!i_Rst_L) begin
                    hpipe_r <= {SYNC_DELAY{1'b1}};
                    vpipe_r <= {SYNC_DELAY{1'b1}};
                end else begin
                    hpipe_r[0] <= hsync_r;
                    vpipe_r[0] <= vsync_r;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        hpipe_r[i] <= hpipe_r[i-1];
                        vpipe_r[i] <= vpipe_r[i-1];
                    end
                end
            end

            assign vga.hsync_dly = hpipe_r[SYNC_DELAY-1];
            assign vga.vsync_dly = vpipe_r[SYNC_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a shrunken raster (with a 2-stage sync delay) and a default 800x525 raster.
module tb_vga_sync_gen;

    logic clk;
    logic rst_n;

    vga_sync_if s_if ();
    vga_sync_if d_if ();

    // Small raster: 20x12, visible 12x8, hsync cols 14..16, vsync rows 9..10, frame = 240 cycles.
    vga_sync_gen #(
        .TOTAL_COLS(20), .TOTAL_ROWS(12), .ACTIVE_COLS(12), .ACTIVE_ROWS(8),
        .H_FRONT(2), .H_SYNC(3), .V_FRONT(1), .V_SYNC(2), .SYNC_DELAY(2)
    ) u_small (
        .i_Clk  (clk),
        .i_Rst_L(rst_n),
        .vga    (s_if.master)
    );

    vga_sync_gen u_default (
        .i_Clk  (clk),
        .i_Rst_L(rst_n),
        .vga    (d_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [9:0] col;
        logic [9:0] row;
        logic       act;
        logic       hs;
        logic       vs;
        logic       fs;
    } vec_t;

    vec_t s_tab[20];
    vec_t d_tab[10];

    int checks = 0;
    int errors = 0;

    logic s_hs_hist[0:1023];
    logic s_vs_hist[0:1023];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {col,row,active,hsync,vsync,frame_start}
    function automatic logic [23:0] pk_s();
        return {s_if.col_count, s_if.row_count, s_if.active, s_if.hsync, s_if.vsync, s_if.frame_start};
    endfunction

    function automatic logic [23:0] pk_d();
        return {d_if.col_count, d_if.row_count, d_if.active, d_if.hsync, d_if.vsync, d_if.frame_start};
    endfunction

    function automatic logic [23:0] pk_v(input vec_t v);
        return {v.col, v.row, v.act, v.hs, v.vs, v.fs};
    endfunction

    function automatic logic [23:0] model(input int n, input int tc, input int tr, input int ac,
                                          input int ar, input int h0, input int h1,
                                          input int v0, input int v1);
        int c, r;
        logic a, h, v, f;
        c = n % tc;
        r = (n / tc) % tr;
        a = (c < ac) && (r < ar);
        h = !((c >= h0) && (c <= h1));
        v = !((r >= v0) && (r <= v1));
        f = (c == 0) && (r == 0);
        return {10'(c), 10'(r), a, h, v, f};
    endfunction

    localparam logic [25:0] RST_VAL = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    function automatic logic [25:0] rst_s();
        return {pk_s(), s_if.hsync_dly, s_if.vsync_dly};
    endfunction

    function automatic logic [25:0] rst_d();
        return {pk_d(), d_if.hsync_dly, d_if.vsync_dly};
    endfunction

    initial begin
        logic [23:0] ms, md;
        logic        exp_hd, exp_vd;
        int          last_fs, vs_low, act_cnt;

        s_tab[0]  = '{0,   10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b1};
        s_tab[1]  = '{1,   10'd1,  10'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        s_tab[2]  = '{11,  10'd11, 10'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        s_tab[3]  = '{12,  10'd12, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0};
        s_tab[4]  = '{13,  10'd13, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0};
        s_tab[5]  = '{14,  10'd14, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0};
        s_tab[6]  = '{16,  10'd16, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0};
        s_tab[7]  = '{17,  10'd17, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0};
        s_tab[8]  = '{19,  10'd19, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0};
        s_tab[9]  = '{20,  10'd0,  10'd1,  1'b1, 1'b1, 1'b1, 1'b0};
        s_tab[10] = '{159, 10'd19, 10'd7,  1'b0, 1'b1, 1'b1, 1'b0};
        s_tab[11] = '{160, 10'd0,  10'd8,  1'b0, 1'b1, 1'b1, 1'b0};
        s_tab[12] = '{179, 10'd19, 10'd8,  1'b0, 1'b1, 1'b1, 1'b0};
        s_tab[13] = '{180, 10'd0,  10'd9,  1'b0, 1'b1, 1'b0, 1'b0};
        s_tab[14] = '{219, 10'd19, 10'd10, 1'b0, 1'b1, 1'b0, 1'b0};
        s_tab[15] = '{220, 10'd0,  10'd11, 1'b0, 1'b1, 1'b1, 1'b0};
        s_tab[16] = '{239, 10'd19, 10'd11, 1'b0, 1'b1, 1'b1, 1'b0};
        s_tab[17] = '{240, 10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b1};
        s_tab[18] = '{241, 10'd1,  10'd0,  1'b1, 1'b1, 1'b1, 1'b0};
        s_tab[19] = '{480, 10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b1};

        d_tab[0] = '{0,   10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        d_tab[1] = '{639, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        d_tab[2] = '{640, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        d_tab[3] = '{655, 10'd655, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        d_tab[4] = '{656, 10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        d_tab[5] = '{751, 10'd751, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        d_tab[6] = '{752, 10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        d_tab[7] = '{799, 10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        d_tab[8] = '{800, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0};
        d_tab[9] = '{999, 10'd199, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("small_reset_vals", 32'(rst_s()), 32'(RST_VAL));
        chk("dflt_reset_vals",  32'(rst_d()), 32'(RST_VAL));
        rst_n = 1'b1;

        last_fs = -1;
        vs_low  = 0;
        act_cnt = 0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            @(negedge clk);
            ms = model(n, 20, 12, 12, 8, 14, 16, 9, 10);
            md = model(n, 800, 525, 640, 480, 656, 751, 490, 491);
            s_hs_hist[n] = ms[2];
            s_vs_hist[n] = ms[1];

            for (int t = 0; t < 20; t++)
                if (s_tab[t].n == n) chk($sformatf("small_vec_n%0d", n), 32'(pk_s()), 32'(pk_v(s_tab[t])));
            for (int t = 0; t < 10; t++)
                if (d_tab[t].n == n) chk($sformatf("dflt_vec_n%0d", n), 32'(pk_d()), 32'(pk_v(d_tab[t])));

            chk($sformatf("small_model_n%0d", n), 32'(pk_s()), 32'(ms));
            chk($sformatf("dflt_model_n%0d", n),  32'(pk_d()), 32'(md));

            exp_hd = (n >= 2) ? s_hs_hist[n-2] : 1'b1;
            exp_vd = (n >= 2) ? s_vs_hist[n-2] : 1'b1;
            chk($sformatf("small_dly_n%0d", n), 32'({s_if.hsync_dly, s_if.vsync_dly}), 32'({exp_hd, exp_vd}));
            chk($sformatf("dflt_dly_n%0d", n), 32'({d_if.hsync_dly, d_if.vsync_dly}), 32'({md[2], md[1]}));

            if (s_if.frame_start === 1'b1) begin
                if (last_fs >= 0) chk("small_frame_period", 32'(n - last_fs), 32'd240);
                last_fs = n;
            end
            if (n < 240 && s_if.vsync === 1'b0) vs_low++;
            if (n < 20 && s_if.active === 1'b1) act_cnt++;
        end
        chk("small_last_fs_index", 32'(last_fs), 32'd960);
        chk("small_vsync_low_cycles", 32'(vs_low), 32'd40);
        chk("small_active_per_line", 32'(act_cnt), 32'd12);

        // Mid-frame reset of the small raster at row 5 col 10 (n = 110).
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n <= 110; n++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_reset_pos", 32'({s_if.col_count, s_if.row_count}), 32'({10'd10, 10'd5}));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_small", 32'(rst_s()), 32'(RST_VAL));
        chk("async_reset_dflt",  32'(rst_d()), 32'(RST_VAL));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("held_reset_small", 32'(rst_s()), 32'(RST_VAL));
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("restart_first", 32'(pk_s()), 32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1}));
        chk("restart_first_dly", 32'({s_if.hsync_dly, s_if.vsync_dly}), 32'(2'b11));
        @(posedge clk);
        @(negedge clk);
        chk("restart_second", 32'(pk_s()), 32'({10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}));
        chk("restart_second_dflt", 32'(pk_d()), 32'({10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
